// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the fetch/data memory arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic {SEL_IF, SEL_D} sel_t;
    localparam int CNT_W = 4;
endpackage

// File: rtl/mem_arb_ibuf.sv
// mem_arb_ibuf: one-entry fetch buffer (tag, data, valid) used when MEM_ARB_IBUF_EN is defined
// Ports: lookup_addr/hit/hit_data probe the entry; load/load_addr/load_data refill it after a
//        memory fetch; wr/wr_addr invalidate it when a data write targets the buffered address.
module mem_arb_ibuf (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] lookup_addr,
    output logic        hit,
    output logic [31:0] hit_data,
    input  logic        load,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    input  logic        wr,
    input  logic [31:0] wr_addr
);
    logic        valid_q, valid_d;
    logic [31:0] tag_q, tag_d, data_q, data_d;

    always_comb begin
        valid_d = load ? 1'b1 : (wr && wr_addr == tag_q) ? 1'b0 : valid_q;
        tag_d   = load ? load_addr : tag_q;
        data_d  = load ? load_data : data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign hit      = valid_q && lookup_addr == tag_q;
    assign hit_data = data_q;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data access
// Ports: if_* fetch requester, d_* data requester, mem_* shared memory port,
//        stall freezes the processor until every raised request has completed.
// Define MEM_ARB_IBUF_EN to add a one-entry fetch buffer that skips memory on a hit.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        stall
);
    state_t           state_q, state_d;
    sel_t             sel_q, sel_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
    logic [31:0]      if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             if_done_q, if_done_d, d_done_q, d_done_d;
    logic             d_req, d_pend, i_pend, last, ib_hit;
    logic [31:0]      ib_data;

    assign d_req     = d_read | d_write;
    // a requester already served in this stall window must not be granted again
    assign d_pend    = d_req & ~d_done_q;
    assign i_pend    = if_req & ~if_done_q;
    assign last      = state_q == ACCESS && cnt_q == '0;
    assign if_ready  = state_q == DONE && sel_q == SEL_IF;
    assign d_ready   = state_q == DONE && sel_q == SEL_D;
    assign stall     = (if_req & ~(if_done_q | if_ready)) | (d_req & ~(d_done_q | d_ready));
    assign mem_read  = state_q == ACCESS && !we_q;
    assign mem_write = state_q == ACCESS && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

`ifdef MEM_ARB_IBUF_EN
    logic ib_fill, ib_wr;
    assign ib_fill = last && sel_q == SEL_IF;
    assign ib_wr   = state_q == IDLE && d_pend && d_write;
    mem_arb_ibuf u_ibuf (
        .clk        (clk),
        .reset      (reset),
        .lookup_addr(if_addr),
        .hit        (ib_hit),
        .hit_data   (ib_data),
        .load       (ib_fill),
        .load_addr  (addr_q),
        .load_data  (mem_rdata),
        .wr         (ib_wr),
        .wr_addr    (d_addr)
    );
`else
    assign ib_hit  = 1'b0;
    assign ib_data = '0;
`endif

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        // clearing wins over setting: once stall drops the processor moves on
        if_done_d  = stall & (if_done_q | if_ready);
        d_done_d   = stall & (d_done_q | d_ready);
        case (state_q)
            IDLE: begin
                if (d_pend) begin
                    sel_d   = SEL_D;
                    we_d    = d_write;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    cnt_d   = CNT_W'(MEM_LATENCY - 1);
                    state_d = ACCESS;
                end else if (i_pend) begin
                    sel_d      = SEL_IF;
                    we_d       = 1'b0;
                    addr_d     = if_addr;
                    cnt_d      = CNT_W'(MEM_LATENCY - 1);
                    state_d    = ib_hit ? DONE : ACCESS;
                    if_rdata_d = ib_hit ? ib_data : if_rdata_q;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (last) begin
                    state_d    = DONE;
                    if_rdata_d = sel_q == SEL_IF ? mem_rdata : if_rdata_q;
                    d_rdata_d  = (sel_q == SEL_D && !we_q) ? mem_rdata : d_rdata_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            sel_q      <= SEL_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_done_q  <= if_done_d;
            d_done_q   <= d_done_d;
        end
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 2, memory access cycles per transfer, legal range 1..15.
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock, sole clock.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  instruction fetch request.
- if_addr  in  32  fetch address.
- if_rdata  out  32  fetched instruction.
- if_ready  out  1  one-cycle fetch completion pulse.
- d_read  in  1  data read request.
- d_write  in  1  data write request.
- d_addr  in  32  data address.
- d_wdata  in  32  write data.
- d_rdata  out  32  read data.
- d_ready  out  1  one-cycle data completion pulse.
- mem_addr  out  32  shared memory address.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data.
- stall  out  1  processor freeze; PC and register writes held while high.

Function
REQ-003 SHALL share one memory port between fetch and data requesters using FSM states IDLE, ACCESS, DONE.
REQ-004 In IDLE, SHALL grant data when an unserved data request is pending, else fetch when an unserved if_req is pending, else stay IDLE; a grant latches requester, address, write data and direction, and moves to ACCESS.
REQ-005 SHALL hold mem_addr, mem_read or mem_write, and mem_wdata constant for exactly MEM_LATENCY ACCESS cycles; both strobes SHALL be 0 outside ACCESS.
REQ-006 SHALL capture mem_rdata on the final ACCESS cycle, then enter DONE for one cycle, pulse the granted requester's ready, and return to IDLE.
REQ-007 Latency: with a request sampled in IDLE at cycle 0, ready SHALL be high at cycle MEM_LATENCY+1.
REQ-008 If d_read and d_write are both high, the write SHALL win and the read SHALL be ignored for that transaction.
REQ-009 if_rdata and d_rdata SHALL be registered and hold their last captured value until the next capture; write transactions SHALL NOT update d_rdata.
REQ-010 SHALL keep sticky flags if_done and d_done, set on the respective ready pulse and cleared in any cycle where stall is 0.
REQ-011 stall SHALL be (if_req and not (if_done or if_ready)) or ((d_read or d_write) and not (d_done or d_ready)), combinationally.
REQ-012 A request deasserted mid-access SHALL NOT abort the transfer; the ready pulse SHALL still occur.
REQ-013 Requesters SHALL hold address and data stable until their ready pulse; a change before then is ignored because values are latched at grant.

Reset
REQ-014 On reset, SHALL enter IDLE and set mem_read=0, mem_write=0, if_ready=0, d_ready=0, if_rdata=0, d_rdata=0, mem_addr=0, mem_wdata=0, if_done=0, d_done=0.
REQ-015 Reset asserted during ACCESS or DONE SHALL drop the strobes at the next edge and suppress the pending ready pulse.

Configuration
REQ-016 Macro MEM_ARB_IBUF_EN SHALL compile in a one-entry fetch buffer (tag, data, valid); without it every fetch goes to memory.
REQ-017 With the buffer, a fetch grant whose if_addr equals a valid tag SHALL skip ACCESS and go IDLE->DONE, so ready appears at cycle 1.
REQ-018 With the buffer, every completed memory fetch SHALL load tag/data and set valid; a data write whose address equals the tag SHALL clear valid; reset SHALL clear valid.

Structure
REQ-019 Package mem_arb_pkg SHALL hold the state enum, the requester-select enum, and the latency-counter width constant (4).
REQ-020 The fetch buffer SHALL be the sub-module mem_arb_ibuf, instantiated only under MEM_ARB_IBUF_EN.

Verification
REQ-021 MEM_LATENCY=2, if_req at 0x0000_0040, mem_rdata=0x2008_0005 -> mem_read high for cycles 1-2, if_ready and if_rdata=0x2008_0005 at cycle 3, stall low at cycle 3.
REQ-022 if_req and d_read together (d_addr 0x100) -> data is served first, with d_ready at cycle 3 and if_ready at cycle 7; stall is high through cycle 6 and low at cycle 7.
REQ-023 d_write and d_read both high, d_addr 0x200, d_wdata 0xDEAD_BEEF -> mem_write high for 2 cycles with mem_wdata=0xDEAD_BEEF, mem_read stays 0, d_rdata unchanged.
REQ-024 reset pulsed in the second ACCESS cycle -> strobes are 0 next cycle, no ready pulse occurs, all outputs are at reset values.
REQ-025 With MEM_ARB_IBUF_EN, fetch 0x40, then fetch 0x40 -> second if_ready at cycle 1 with no mem_read; after a write to 0x40, the next fetch of 0x40 accesses memory.
REQ-026 MEM_LATENCY=1 and MEM_LATENCY=15 -> ACCESS lasts exactly 1 and 15 cycles respectively.
